instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word address of the first fetch after reset.
REQ-002 Port clk  input  1: sole clock; all state updates on posedge clk.
REQ-003 Port rst  input  1: reset, synchronous and active-high.
REQ-004 Port stall  input  1: decode cannot accept; hold the presented instruction.
REQ-005 Port branch_taken  input  1: single-cycle redirect request from execute.
REQ-006 Port branch_target  input  32: word address to fetch when branch_taken=1.
REQ-007 Port imem_addr  output  32: word address to the instruction memory; memory returns the data one cycle later.
REQ-008 Port imem_data  input  32: memory read data, registered in memory; equals mem[imem_addr of previous cycle].
REQ-009 Port if_valid  output  1: if_instr/if_pc hold a real instruction this cycle.
REQ-010 Port if_pc  output  32: word address of the presented instruction.
REQ-011 Port if_instr  output  32: presented instruction; 32'h0 whenever if_valid=0.

Function
REQ-012 State: pc (next address to issue), req_pc (address issued last cycle), req_valid (last issue not flushed).
REQ-013 Normal cycle (stall=0, branch_taken=0): pc<=pc+1, req_pc<=pc, req_valid<=1.
REQ-014 if_valid=req_valid; if_pc=req_pc; if_instr=imem_data (or skid, REQ-024) when if_valid=1.
REQ-015 Issue-to-present latency: 1 cycle; steady-state throughput: 1 instruction/cycle.
REQ-016 pc increment wraps 32'hFFFF_FFFF -> 32'h0000_0000 with no other side effect.
REQ-017 Redirect: branch_taken=1 at edge -> pc<=branch_target+0 issued next cycle, req_valid<=0; bubble cycle, then if_valid=1, if_pc=branch_target.
REQ-018 Redirect-to-valid latency: exactly 2 cycles after the branch_taken cycle.
REQ-019 Stall: stall=1 and branch_taken=0 -> pc, req_pc, req_valid hold; if_valid/if_pc/if_instr stable for every stalled cycle and the first unstalled cycle.
REQ-020 branch_taken=1 overrides stall=1: redirect per REQ-017, held instruction discarded.
REQ-021 stall with if_valid=0 (bubble): pc holds, if_valid stays 0, no fetch lost.
REQ-022 No instruction skipped or duplicated across any stall/release sequence.

Reset
REQ-023 rst=1 at edge: pc<=RESET_PC, req_pc<=0, req_valid<=0, skid/held cleared; first cycle after rst release drives imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0; next cycle if_valid=1, if_pc=RESET_PC. rst overrides stall and branch_taken.

Configuration
REQ-024 Macro IFETCH_SKID_EN defined: imem_addr=pc always (no combinational stall path to memory); on first stalled cycle's edge imem_data captured into 32-bit skid register, held<=1; if_instr sourced from skid while held=1; held<=0 at first edge with stall=0.
REQ-025 Macro IFETCH_SKID_EN undefined: no skid register; imem_addr=stall ? req_pc : pc so memory re-reads the held word.
REQ-026 Port-visible behaviour identical in both builds.

Structure
REQ-027 Shared package: RESET_PC default, 32-bit word/address width constant, NOP encoding 32'h0.
REQ-028 Single flat module; skid register inline (no sub-module).

Verification
REQ-029 Reset release, memory preloaded mem[0]=32'h00801002, mem[1]=32'h00801003 -> cycle1 if_valid=1 if_pc=0 if_instr=32'h00801002; cycle2 if_pc=1 if_instr=32'h00801003.
REQ-030 stall=1 for 3 cycles while if_pc=2 -> if_pc=2, if_instr=mem[2] for 4 cycles, then if_pc=3; no skip.
REQ-031 branch_taken=1, branch_target=0 at if_pc=3 -> next cycle if_valid=0, following cycle if_valid=1 if_pc=0.
REQ-032 branch_taken=1 and stall=1 same cycle, target=5 -> bubble, then if_pc=5; stalled instruction dropped.
REQ-033 RESET_PC=32'hFFFF_FFFF -> if_pc sequence FFFF_FFFF, 0000_0000, 0000_0001.
REQ-034 rst=1 mid-stall with held instruction -> next cycle if_valid=0, imem_addr=RESET_PC; run with and without IFETCH_SKID_EN, traces identical.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared constants for the instruction fetch stage:
//   XLEN             - word / address width (32)
//   RESET_PC_DEFAULT - default word address of the first fetch after reset
//   NOP_INSTR        - encoding presented on if_instr when no instruction is valid
//   pc_next()        - sequential word-address increment (wraps naturally)
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

    // Modulo-2^32 increment: 32'hFFFF_FFFF rolls over to 32'h0000_0000.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Single-stage fetch unit in front of a synchronous (1-cycle read latency)
// instruction memory. Issues one word address per cycle, presents the
// returned word to decode one cycle later, and supports decode back-pressure
// (stall) and single-cycle redirects (branch_taken) from execute.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   decode cannot accept; hold the presented instruction
//   branch_taken   in   redirect request (overrides stall)
//   branch_target  in   [31:0] word address to fetch on redirect
//   imem_addr      out  [31:0] word address to instruction memory
//   imem_data      in   [31:0] memory data for previous cycle's imem_addr
//   if_valid       out  presented instruction is real
//   if_pc          out  [31:0] word address of presented instruction
//   if_instr       out  [31:0] presented instruction, NOP_INSTR when invalid
//
// Build option:
//   IFETCH_SKID_EN defined   - memory address is always pc; the word presented
//                              during a stall is parked in a skid register.
//   IFETCH_SKID_EN undefined - no skid register; during a stall the memory is
//                              pointed back at the held address so it re-reads
//                              the same word every cycle.
//   Both builds present identical if_* behaviour.
// ----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] req_pc_q,    req_pc_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] instr_src;

    // A redirect wins over a stall: the held instruction is dropped and the
    // request issued this cycle (if any) is marked as flushed.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        if (branch_taken) begin
            pc_d        = branch_target;
            req_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d        = pc_next(pc_q);
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

`ifdef IFETCH_SKID_EN
    logic            held_q, held_d;
    logic [XLEN-1:0] skid_q, skid_d;

    // Capture only on the first stalled edge: imem_data is still the word
    // for req_pc then, and afterwards the memory is reading pc instead.
    always_comb begin
        held_d = held_q;
        skid_d = skid_q;
        if (branch_taken) begin
            held_d = 1'b0;
        end else if (stall) begin
            if (!held_q) begin
                skid_d = imem_data;
                held_d = 1'b1;
            end
        end else begin
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= 1'b0;
            skid_q <= '0;
        end else begin
            held_q <= held_d;
            skid_q <= skid_d;
        end
    end

    assign imem_addr = pc_q;
    assign instr_src = held_q ? skid_q : imem_data;
`else
    // Re-read the held word while stalled. During a stalled bubble there is
    // nothing to hold, so keep pointing at pc (also makes the first cycle
    // after reset show RESET_PC even if stall is already asserted).
    assign imem_addr = (stall && req_valid_q) ? req_pc_q : pc_q;
    assign instr_src = imem_data;
`endif

    assign if_valid = req_valid_q;
    assign if_pc    = req_pc_q;
    assign if_instr = req_valid_q ? instr_src : NOP_INSTR;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst, stall, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_data, if_pc, if_instr;
    logic        if_valid;

    // wrap DUT (RESET_PC = FFFF_FFFF), free-running
    logic        rst_w;
    logic        zero1  = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic [31:0] imem_addr_w, imem_data_w, if_pc_w, if_instr_w;
    logic        if_valid_w;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk           (clk),
        .rst           (rst_w),
        .stall         (zero1),
        .branch_taken  (zero1),
        .branch_target (zero32),
        .imem_addr     (imem_addr_w),
        .imem_data     (imem_data_w),
        .if_valid      (if_valid_w),
        .if_pc         (if_pc_w),
        .if_instr      (if_instr_w)
    );

    // memory contents as a pure function of address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'd0) return 32'h0080_1002;
        if (a == 32'd1) return 32'h0080_1003;
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // synchronous memories, one-cycle read latency
    always @(posedge clk) begin
        imem_data   <= mem_f(imem_addr);
        imem_data_w <= mem_f(imem_addr_w);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream-level reference: what decode should see, and where the next
    // fetch comes from, after each clock edge.
    bit          chk_en = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_nf = 32'h0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0;
                m_pc    = 32'h0;
                m_nf    = 32'h0;
                chk_en  = 1'b1;
            end else if (branch_taken) begin
                m_valid = 1'b0;
                m_nf    = branch_target;
            end else if (!stall) begin
                m_valid = 1'b1;
                m_pc    = m_nf;
                m_nf    = m_nf + 32'd1;
            end
        end
    end

    // Per-cycle compare, plus an ordering check on accepted instructions
    // (each accepted pc follows the previous one unless redirected/reset).
    logic [31:0] seq_exp = 32'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", 32'(if_valid), 32'(m_valid));
                if (m_valid) check("pc", if_pc, m_pc);
                check("instr", if_instr, m_valid ? mem_f(m_pc) : 32'h0);
                if (!stall) check("imem_addr", imem_addr, m_nf);
                if (rst) begin
                    seq_exp = 32'h0;
                end else if (branch_taken) begin
                    seq_exp = branch_target;
                end else if (if_valid && !stall) begin
                    check("order", if_pc, seq_exp);
                    seq_exp = if_pc + 32'd1;
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        rst_w         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        step();
        step();
        rst   = 1'b0;
        rst_w = 1'b0;

        // first cycle after reset release
        check("rel_valid", 32'(if_valid), 32'd0);
        check("rel_pc", if_pc, 32'h0);
        check("rel_instr", if_instr, 32'h0);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_w_valid", 32'(if_valid_w), 32'd0);
        check("rel_w_addr", imem_addr_w, 32'hFFFF_FFFF);

        step();
        check("c1_valid", 32'(if_valid), 32'd1);
        check("c1_pc", if_pc, 32'h0);
        check("c1_instr", if_instr, 32'h0080_1002);
        check("w_c1_pc", if_pc_w, 32'hFFFF_FFFF);
        check("w_c1_instr", if_instr_w, mem_f(32'hFFFF_FFFF));

        step();
        check("c2_pc", if_pc, 32'h1);
        check("c2_instr", if_instr, 32'h0080_1003);
        check("w_c2_pc", if_pc_w, 32'h0);
        check("w_c2_instr", if_instr_w, 32'h0080_1002);

        step();
        check("c3_pc", if_pc, 32'h2);
        check("w_c3_pc", if_pc_w, 32'h1);

        // stall three cycles while pc 2 is presented
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_pc", if_pc, 32'h2);
            check("stall_instr", if_instr, mem_f(32'h2));
            step();
        end
        stall = 1'b0;
        check("rel4_pc", if_pc, 32'h2);
        check("rel4_instr", if_instr, mem_f(32'h2));
        step();
        check("after_stall_pc", if_pc, 32'h3);
        check("after_stall_instr", if_instr, mem_f(32'h3));

        // redirect to 0 at pc 3
        branch_taken  = 1'b1;
        branch_target = 32'h0;
        step();
        branch_taken = 1'b0;
        check("br_bubble", 32'(if_valid), 32'd0);
        check("br_bubble_instr", if_instr, 32'h0);
        step();
        check("br_valid", 32'(if_valid), 32'd1);
        check("br_pc", if_pc, 32'h0);
        check("br_instr", if_instr, 32'h0080_1002);

        // redirect together with stall, target 5
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h5;
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        check("brst_bubble", 32'(if_valid), 32'd0);
        step();
        check("brst_valid", 32'(if_valid), 32'd1);
        check("brst_pc", if_pc, 32'h5);
        check("brst_instr", if_instr, mem_f(32'h5));

        // reset in the middle of a stall with an instruction held
        stall = 1'b1;
        step();
        step();
        check("held_pc", if_pc, 32'h5);
        check("held_instr", if_instr, mem_f(32'h5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_stall_valid", 32'(if_valid), 32'd0);
        check("rst_stall_addr", imem_addr, 32'h0);
        check("rst_stall_instr", if_instr, 32'h0);
        stall = 1'b0;
        step();
        check("rst_stall_c1_valid", 32'(if_valid), 32'd1);
        check("rst_stall_c1_pc", if_pc, 32'h0);

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            branch_taken  = ($urandom_range(0, 15) == 0);
            branch_target = ($urandom_range(0, 3) == 0)
                          ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                          : 32'($urandom_range(0, 63));
            step();
        end

        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
